// File: rtl/cpu_boot_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_boot_ctrl
//
// Run sequencer for the pipelined cpu. It sits between the host stream
// interface and the cpu top level. After a start request it:
//   1. streams imem_words words from the load stream into instruction memory,
//   2. streams dmem_words words from the same load stream into data memory,
//   3. holds cpu_enable high for exactly run_cycles cycles,
//   4. reads the first dmem_words words of data memory back out on the
//      dump stream,
// and then pulses done for one cycle. Empty phases are skipped.
//
// Ports:
//   clk, arst                      clock, asynchronous active-high reset
//   start                          begin a sequence (only honoured in IDLE)
//   imem_words, dmem_words,
//   run_cycles                     sequence lengths, latched on start
//   in_valid/in_ready/in_data      load stream (valid/ready handshake)
//   out_valid/out_ready/out_data   dump stream (valid/ready handshake)
//   addr_ext/wen_ext/ren_ext/
//   wdata_ext                      instruction memory external port
//   addr_ext_2/wen_ext_2/
//   ren_ext_2/wdata_ext_2          data memory external port
//   rdata_ext_2                    data memory read data, one cycle after
//                                  ren_ext_2
//   cpu_enable                     cpu run enable
//   busy                           high in every state except IDLE
//   done                           one-cycle completion pulse
//   cycle_count                    enabled cycles of the current/last run
// -----------------------------------------------------------------------------
module cpu_boot_ctrl #(
  parameter int IMEM_CNT_W = 10,
  parameter int DMEM_CNT_W = 11,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [IMEM_CNT_W-1:0] imem_words,
  input  logic [DMEM_CNT_W-1:0] dmem_words,
  input  logic [31:0]           run_cycles,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [31:0]           addr_ext,
  output logic                  wen_ext,
  output logic                  ren_ext,
  output logic [31:0]           wdata_ext,
  output logic [31:0]           addr_ext_2,
  output logic                  wen_ext_2,
  output logic                  ren_ext_2,
  output logic [31:0]           wdata_ext_2,
  input  logic [31:0]           rdata_ext_2,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_I,
    LOAD_D,
    RUN,
    DUMP_RD,
    DUMP_WT,
    DUMP_OUT,
    FIN
  } state_t;

  state_t                  state, state_nxt;
  logic [IMEM_CNT_W-1:0]   imem_q;
  logic [DMEM_CNT_W-1:0]   dmem_q;
  logic [31:0]             run_q;
  logic [DMEM_CNT_W-1:0]   wc, wc_nxt;
  logic [31:0]             cycle_nxt;
  logic [31:0]             out_nxt;
  logic                    cfg_load;

  logic [31:0]             wc_addr;
  logic                    last_i;
  logic                    last_d;

  // The word counter is shared by both loads and the dump, so the byte
  // address and the "this is the final word" tests are derived once here.
  // The comparisons are done at 32 bits so the two count widths never have
  // to agree with each other.
  assign wc_addr = 32'(wc) * 32'(ADDR_STEP);
  assign last_i  = (32'(wc) + 32'd1) == 32'(imem_q);
  assign last_d  = (32'(wc) + 32'd1) == 32'(dmem_q);

  // State and datapath registers. Reset drops straight back to IDLE with all
  // counters cleared; since every port strobe is decoded from the state, an
  // abort stops memory writes and cpu_enable in the same instant.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      imem_q      <= '0;
      dmem_q      <= '0;
      run_q       <= '0;
      wc          <= '0;
      cycle_count <= '0;
      out_data    <= '0;
    end else begin
      state       <= state_nxt;
      wc          <= wc_nxt;
      cycle_count <= cycle_nxt;
      out_data    <= out_nxt;
      if (cfg_load) begin
        imem_q <= imem_words;
        dmem_q <= dmem_words;
        run_q  <= run_cycles;
      end
    end
  end

  // Next-state and output decode. Every port is owned by exactly one group of
  // states, which keeps the two write enables and cpu_enable mutually
  // exclusive by construction. When leaving a phase the choice of the next
  // phase skips any phase whose length is zero. In IDLE the raw inputs are
  // used for that choice because the latched copies only update at the edge.
  // The run ends on the cycle whose increment reaches run_cycles, so
  // cpu_enable is high for exactly that many cycles.
  always_comb begin
    state_nxt   = state;
    wc_nxt      = wc;
    cycle_nxt   = cycle_count;
    out_nxt     = out_data;
    cfg_load    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    cpu_enable  = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          cfg_load  = 1'b1;
          wc_nxt    = '0;
          cycle_nxt = '0;
          if (imem_words != '0)      state_nxt = LOAD_I;
          else if (dmem_words != '0) state_nxt = LOAD_D;
          else if (run_cycles != '0) state_nxt = RUN;
          else                       state_nxt = FIN;
        end
      end

      LOAD_I: begin
        in_ready  = 1'b1;
        wen_ext   = in_valid;
        addr_ext  = wc_addr;
        wdata_ext = in_data;
        if (in_valid) begin
          if (last_i) begin
            wc_nxt = '0;
            if (dmem_q != '0)     state_nxt = LOAD_D;
            else if (run_q != '0) state_nxt = RUN;
            else                  state_nxt = FIN;
          end else begin
            wc_nxt = wc + 1'b1;
          end
        end
      end

      LOAD_D: begin
        in_ready    = 1'b1;
        wen_ext_2   = in_valid;
        addr_ext_2  = wc_addr;
        wdata_ext_2 = in_data;
        if (in_valid) begin
          if (last_d) begin
            wc_nxt    = '0;
            state_nxt = (run_q != '0) ? RUN : DUMP_RD;
          end else begin
            wc_nxt = wc + 1'b1;
          end
        end
      end

      RUN: begin
        cpu_enable = 1'b1;
        cycle_nxt  = cycle_count + 32'd1;
        if (cycle_nxt == run_q) begin
          state_nxt = (dmem_q != '0) ? DUMP_RD : FIN;
        end
      end

      DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = wc_addr;
        state_nxt  = DUMP_WT;
      end

      DUMP_WT: begin
        out_nxt   = rdata_ext_2;
        state_nxt = DUMP_OUT;
      end

      DUMP_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last_d) begin
            wc_nxt    = '0;
            state_nxt = FIN;
          end else begin
            wc_nxt    = wc + 1'b1;
            state_nxt = DUMP_RD;
          end
        end
      end

      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_boot_ctrl
//
// Bench for cpu_boot_ctrl. A phase-level model of the boot sequence predicts
// every output each cycle; a small data memory model answers the dump reads.
// Directed sequences exercise each phase and the skip, stall, abort and
// ignored-start cases, and literal expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  imem_words = '0;
  logic [10:0] dmem_words = '0;
  logic [31:0] run_cycles = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  logic [31:0] stream [0:63];

  int n_wen = 0, n_wen2 = 0, n_ren2 = 0, n_cpu = 0, n_done = 0;
  int n_busy = 0, n_ov = 0, n_hs = 0;
  logic [31:0] addr_log [$];
  logic [31:0] data_log [$];
  logic [31:0] dump_log [$];

  always #5 clk = ~clk;

  cpu_boot_ctrl dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .imem_words  (imem_words),
    .dmem_words  (dmem_words),
    .run_cycles  (run_cycles),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .cpu_enable  (cpu_enable),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  // Data memory stand-in: word addressed, read data one cycle after the read.
  logic [31:0] dmem [0:63];
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[7:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[7:2]];
    else           rdata_ext_2 <= 32'hDEADBEEF;
  end

  // Phases in sequence order: 0 idle, 1 imem load, 2 dmem load, 3 run,
  // 4 dump, 5 finish. The next phase is the first later one with work to do.
  function automatic int next_phase(input int after, input int ni, input int nd,
                                    input logic [31:0] nr);
    for (int p = after + 1; p < 5; p++) begin
      if ((p == 1 && ni != 0) || (p == 2 && nd != 0) ||
          (p == 3 && nr != 0) || (p == 4 && nd != 0)) return p;
    end
    return 5;
  endfunction

  // Sequence model. m_wc counts words done in the current phase, m_sub is
  // the read/wait/present step of one dump word.
  int          m_ph, m_sub, m_wc, m_ni, m_nd;
  logic [31:0] m_nr, m_cc;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_ph <= 0; m_sub <= 0; m_wc <= 0; m_ni <= 0; m_nd <= 0;
      m_nr <= '0; m_cc <= '0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ni  <= int'(imem_words);
          m_nd  <= int'(dmem_words);
          m_nr  <= run_cycles;
          m_wc  <= 0;
          m_cc  <= '0;
          m_sub <= 0;
          m_ph  <= next_phase(0, int'(imem_words), int'(dmem_words), run_cycles);
        end
        1, 2: if (in_valid) begin
          if (m_wc + 1 == ((m_ph == 1) ? m_ni : m_nd)) begin
            m_wc <= 0;
            m_ph <= next_phase(m_ph, m_ni, m_nd, m_nr);
          end else begin
            m_wc <= m_wc + 1;
          end
        end
        3: begin
          m_cc <= m_cc + 32'd1;
          if (m_cc + 32'd1 == m_nr) m_ph <= next_phase(3, m_ni, m_nd, m_nr);
        end
        4: begin
          if (m_sub < 2) m_sub <= m_sub + 1;
          else if (out_ready) begin
            m_sub <= 0;
            if (m_wc + 1 == m_nd) begin
              m_wc <= 0;
              m_ph <= 5;
            end else begin
              m_wc <= m_wc + 1;
            end
          end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus activity tallies used by
  // the literal checks after each sequence.
  task automatic compareLoop();
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        checkOutput("busy",       busy,       m_ph != 0);
        checkOutput("done",       done,       m_ph == 5);
        checkOutput("in_ready",   in_ready,   m_ph == 1 || m_ph == 2);
        checkOutput("wen_ext",    wen_ext,    m_ph == 1 && in_valid);
        checkOutput("wen_ext_2",  wen_ext_2,  m_ph == 2 && in_valid);
        checkOutput("ren_ext",    ren_ext,    1'b0);
        checkOutput("ren_ext_2",  ren_ext_2,  m_ph == 4 && m_sub == 0);
        checkOutput("cpu_enable", cpu_enable, m_ph == 3);
        checkOutput("out_valid",  out_valid,  m_ph == 4 && m_sub == 2);
        checkOutput("cycle_count", cycle_count, m_cc);
        if (m_ph == 1 && in_valid) begin
          checkOutput("addr_ext",  addr_ext,  32'(m_wc * 4));
          checkOutput("wdata_ext", wdata_ext, in_data);
        end
        if (m_ph == 2 && in_valid) begin
          checkOutput("addr_ext_2",  addr_ext_2,  32'(m_wc * 4));
          checkOutput("wdata_ext_2", wdata_ext_2, in_data);
        end
        if (m_ph == 4 && m_sub == 0)
          checkOutput("addr_ext_2_rd", addr_ext_2, 32'(m_wc * 4));
        if (m_ph == 4 && m_sub == 2)
          checkOutput("out_data", out_data, stream[(m_ni + m_wc) % 64]);
      end
      if (wen_ext) begin n_wen++; addr_log.push_back(addr_ext); data_log.push_back(wdata_ext); end
      if (wen_ext_2) n_wen2++;
      if (ren_ext_2) n_ren2++;
      if (cpu_enable) n_cpu++;
      if (done) n_done++;
      if (busy) n_busy++;
      if (out_valid) n_ov++;
      if (out_valid && out_ready) begin n_hs++; dump_log.push_back(out_data); end
    end
  endtask

  // Runs one whole sequence: programs the counts, pulses start, then feeds
  // the load stream word by word until done. in_valid is either steady or
  // toggling; out_ready is held low for the first 'stall' presented dump
  // cycles; mid_start pulses start with different counts during the load.
  task automatic applyStimulus(input int ni, input int nd, input int nr,
                               input bit toggle, input int stall,
                               input bit mid_start);
    int k;
    int stall_left;
    bit vtog;
    bit acc;
    bit finished;
    k = 0;
    stall_left = stall;
    vtog = 1'b1;
    finished = 1'b0;
    imem_words = 10'(ni);
    dmem_words = 11'(nd);
    run_cycles = 32'(nr);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      in_valid  = toggle ? vtog : 1'b1;
      in_data   = stream[k % 64];
      out_ready = (stall_left == 0);
      if (mid_start && cyc == 1) begin
        start = 1'b1;
        imem_words = 10'd7;
        dmem_words = 11'd5;
        run_cycles = 32'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && stall_left > 0) stall_left--;
      finished = done;
      @(posedge clk); #1;
      if (acc) k++;
      vtog = !vtog;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL timeout: no done within 400 cycles (ni=%0d nd=%0d nr=%0d)", ni, nd, nr);
    end
  endtask

  task automatic mainSeq();
    int b_wen, b_wen2, b_ren2, b_cpu, b_done, b_busy, b_ov, b_hs, b_alog, b_dlog;

    for (int i = 0; i < 64; i++) stream[i] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    cmp_on = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_busy",  busy,        1'b0);
    checkOutput("rst_cycle", cycle_count, 32'd0);
    checkOutput("rst_cpu",   cpu_enable,  1'b0);
    checkOutput("rst_addr2", addr_ext_2,  32'd0);
    checkOutput("rst_out",   out_data,    32'd0);

    $display("[TB] imem load then run, no data memory");
    b_wen = n_wen; b_cpu = n_cpu; b_done = n_done; b_ov = n_ov; b_alog = addr_log.size();
    applyStimulus(3, 0, 5, 1'b0, 0, 1'b0);
    checkOutput("t1_wen_cnt",   32'(n_wen - b_wen),   32'd3);
    checkOutput("t1_addr0",     addr_log[b_alog],     32'd0);
    checkOutput("t1_addr1",     addr_log[b_alog + 1], 32'd4);
    checkOutput("t1_addr2",     addr_log[b_alog + 2], 32'd8);
    checkOutput("t1_data0",     data_log[b_alog],     32'hA0);
    checkOutput("t1_data2",     data_log[b_alog + 2], 32'hA2);
    checkOutput("t1_cpu_cnt",   32'(n_cpu - b_cpu),   32'd5);
    checkOutput("t1_cycle",     cycle_count,          32'd5);
    checkOutput("t1_done_cnt",  32'(n_done - b_done), 32'd1);
    checkOutput("t1_ov_cnt",    32'(n_ov - b_ov),     32'd0);

    $display("[TB] both loads with gappy valid, no run, dump");
    b_wen = n_wen; b_wen2 = n_wen2; b_ren2 = n_ren2; b_cpu = n_cpu; b_dlog = dump_log.size();
    applyStimulus(2, 2, 0, 1'b1, 0, 1'b0);
    checkOutput("t2_wen_cnt",  32'(n_wen - b_wen),   32'd2);
    checkOutput("t2_wen2_cnt", 32'(n_wen2 - b_wen2), 32'd2);
    checkOutput("t2_ren2_cnt", 32'(n_ren2 - b_ren2), 32'd2);
    checkOutput("t2_cpu_cnt",  32'(n_cpu - b_cpu),   32'd0);
    checkOutput("t2_dump0",    dump_log[b_dlog],     32'hA2);
    checkOutput("t2_dump1",    dump_log[b_dlog + 1], 32'hA3);
    checkOutput("t2_cycle",    cycle_count,          32'd0);

    $display("[TB] dump with consumer stall");
    b_ren2 = n_ren2; b_ov = n_ov; b_hs = n_hs; b_dlog = dump_log.size();
    applyStimulus(0, 2, 1, 1'b0, 4, 1'b0);
    checkOutput("t3_ren2_cnt", 32'(n_ren2 - b_ren2), 32'd2);
    checkOutput("t3_ov_cnt",   32'(n_ov - b_ov),     32'd6);
    checkOutput("t3_hs_cnt",   32'(n_hs - b_hs),     32'd2);
    checkOutput("t3_dump0",    dump_log[b_dlog],     32'hA0);
    checkOutput("t3_dump1",    dump_log[b_dlog + 1], 32'hA1);

    $display("[TB] all counts zero");
    b_busy = n_busy; b_done = n_done; b_wen = n_wen; b_wen2 = n_wen2; b_cpu = n_cpu;
    applyStimulus(0, 0, 0, 1'b0, 0, 1'b0);
    checkOutput("t4_busy_cnt", 32'(n_busy - b_busy), 32'd1);
    checkOutput("t4_done_cnt", 32'(n_done - b_done), 32'd1);
    checkOutput("t4_wr_cnt",   32'(n_wen - b_wen + n_wen2 - b_wen2), 32'd0);
    checkOutput("t4_cpu_cnt",  32'(n_cpu - b_cpu),   32'd0);

    $display("[TB] reset during run");
    imem_words = '0;
    dmem_words = '0;
    run_cycles = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_cpu_before", cpu_enable,  1'b1);
    checkOutput("t5_cc_before",  cycle_count, 32'd2);
    #1 arst = 1'b1;
    #1;
    checkOutput("t5_cpu_abort",  cpu_enable,  1'b0);
    checkOutput("t5_busy_abort", busy,        1'b0);
    checkOutput("t5_cc_abort",   cycle_count, 32'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    b_cpu = n_cpu; b_done = n_done;
    applyStimulus(1, 1, 3, 1'b0, 0, 1'b0);
    checkOutput("t5_cpu_cnt",  32'(n_cpu - b_cpu),   32'd3);
    checkOutput("t5_cycle",    cycle_count,          32'd3);
    checkOutput("t5_done_cnt", 32'(n_done - b_done), 32'd1);

    $display("[TB] start pulsed while loading");
    b_wen = n_wen; b_wen2 = n_wen2; b_cpu = n_cpu; b_done = n_done; b_dlog = dump_log.size();
    applyStimulus(3, 1, 2, 1'b0, 0, 1'b1);
    checkOutput("t6_wen_cnt",  32'(n_wen - b_wen),   32'd3);
    checkOutput("t6_wen2_cnt", 32'(n_wen2 - b_wen2), 32'd1);
    checkOutput("t6_cpu_cnt",  32'(n_cpu - b_cpu),   32'd2);
    checkOutput("t6_cycle",    cycle_count,          32'd2);
    checkOutput("t6_dump0",    dump_log[b_dlog],     32'hA3);
    checkOutput("t6_done_cnt", 32'(n_done - b_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      compareLoop();
      mainSeq();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
